// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game countdown timer: FSM encoding,
// per-digit BCD limits and the load saturation function.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

    // Clamp an out-of-range BCD digit to the largest legal value for its position.
    function automatic logic [3:0] sat_digit(input logic [3:0] val, input logic [3:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter. Reloads its limit on a borrow from zero
// and reports the borrow combinationally so digits chain within one cycle.
module bcd_down_digit
    import game_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rst_val,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       dec,
    input  logic [3:0] limit,
    output logic [3:0] value,
    output logic       borrow
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        value_d = value_q;
        if (ld) begin
            value_d = ld_val;
        end else if (dec) begin
            value_d = (value_q == 4'd0) ? limit : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= rst_val;
        end else begin
            value_q <= value_d;
        end
    end

    assign value  = value_q;
    assign borrow = dec & (value_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD game time-limit timer with IDLE/RUN/PAUSE/EXPIRED control.
// Optional low-time warning output is built only when COUNTDOWN_WARN_EN is defined.
module countdown_timer
    import game_timer_pkg::*;
#(
    parameter int PRESET_MIN = 3,
    parameter int PRESET_SEC = 0,
    parameter int WARN_SECS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_d3,
    input  logic [3:0] load_d2,
    input  logic [3:0] load_d1,
    input  logic [3:0] load_d0,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    output logic [3:0] digit3,
    output logic [3:0] digit2,
    output logic [3:0] digit1,
    output logic [3:0] digit0,
    output logic       running,
    output logic       time_up,
    output logic       expire_p,
    output logic       warn
);

    localparam logic [3:0] PRESET_D3 = 4'(PRESET_MIN / 10);
    localparam logic [3:0] PRESET_D2 = 4'(PRESET_MIN % 10);
    localparam logic [3:0] PRESET_D1 = 4'(PRESET_SEC / 10);
    localparam logic [3:0] PRESET_D0 = 4'(PRESET_SEC % 10);

    if (PRESET_MIN < 0 || PRESET_MIN > 59 || PRESET_SEC < 0 || PRESET_SEC > 59 ||
        WARN_SECS < 0 || WARN_SECS > 3599) begin : g_param_check
        $error("countdown_timer: parameter out of range");
    end

    state_e     state_q, state_d;
    logic       running_q, running_d;
    logic       time_up_q, time_up_d;
    logic       expire_p_q, expire_p_d;
    logic       warn_q, warn_d;

    logic       load_ok;
    logic       digit_ld;
    logic       dec_en;
    logic       at_zero;
    logic       at_one;
    logic [3:0] ld_v3, ld_v2, ld_v1, ld_v0;
    logic       borrow0, borrow1, borrow2, borrow3;

    assign at_zero = ({digit3, digit2, digit1, digit0} == 16'h0000);
    assign at_one  = ({digit3, digit2, digit1, digit0} == 16'h0001);
    assign load_ok = load & ((state_q == ST_IDLE) | (state_q == ST_EXPIRED));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            running_q  <= 1'b0;
            time_up_q  <= 1'b0;
            expire_p_q <= 1'b0;
            warn_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            time_up_q  <= time_up_d;
            expire_p_q <= expire_p_d;
            warn_q     <= warn_d;
        end
    end

    // abort and an accepted load both force IDLE; a pause in RUN swallows a same-cycle tick.
    always_comb begin
        state_d = state_q;
        dec_en  = 1'b0;
        if (abort || load_ok) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !at_zero) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        dec_en = 1'b1;
                        if (at_one) state_d = ST_EXPIRED;
                    end
                end
                ST_PAUSE: begin
                    if (start && !pause) state_d = ST_RUN;
                end
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d  = (state_d == ST_RUN);
        time_up_d  = (state_d == ST_EXPIRED);
        expire_p_d = (state_q == ST_RUN) && (state_d == ST_EXPIRED);
    end

`ifdef COUNTDOWN_WARN_EN
    logic [11:0] cur_secs;
    logic [11:0] next_secs;

    // Warn tracks the value the digits will hold next cycle so both stay aligned.
    always_comb begin
        cur_secs  = 12'(digit3) * 12'd600 + 12'(digit2) * 12'd60 +
                    12'(digit1) * 12'd10  + 12'(digit0);
        next_secs = cur_secs - 12'(dec_en);
        warn_d    = ((state_d == ST_RUN) || (state_d == ST_PAUSE)) &&
                    (next_secs != 12'd0) && (next_secs <= 12'(WARN_SECS));
    end
`else
    assign warn_d = 1'b0;
`endif

    always_comb begin
        digit_ld = abort | load_ok;
        if (abort) begin
            ld_v3 = PRESET_D3;
            ld_v2 = PRESET_D2;
            ld_v1 = PRESET_D1;
            ld_v0 = PRESET_D0;
        end else begin
            ld_v3 = sat_digit(load_d3, DIGIT_MAX_TENS);
            ld_v2 = sat_digit(load_d2, DIGIT_MAX_ONES);
            ld_v1 = sat_digit(load_d1, DIGIT_MAX_TENS);
            ld_v0 = sat_digit(load_d0, DIGIT_MAX_ONES);
        end
    end

    bcd_down_digit u_d0 (
        .clk(clk), .rst(rst), .rst_val(PRESET_D0), .ld(digit_ld), .ld_val(ld_v0),
        .dec(dec_en), .limit(DIGIT_MAX_ONES), .value(digit0), .borrow(borrow0)
    );
    bcd_down_digit u_d1 (
        .clk(clk), .rst(rst), .rst_val(PRESET_D1), .ld(digit_ld), .ld_val(ld_v1),
        .dec(borrow0), .limit(DIGIT_MAX_TENS), .value(digit1), .borrow(borrow1)
    );
    bcd_down_digit u_d2 (
        .clk(clk), .rst(rst), .rst_val(PRESET_D2), .ld(digit_ld), .ld_val(ld_v2),
        .dec(borrow1), .limit(DIGIT_MAX_ONES), .value(digit2), .borrow(borrow2)
    );
    // The top borrow is never consumed: RUN is left at 00:00 before it could fire.
    bcd_down_digit u_d3 (
        .clk(clk), .rst(rst), .rst_val(PRESET_D3), .ld(digit_ld), .ld_val(ld_v3),
        .dec(borrow2), .limit(DIGIT_MAX_TENS), .value(digit3), .borrow(borrow3)
    );

    assign running  = running_q;
    assign time_up  = time_up_q;
    assign expire_p = expire_p_q;
    assign warn     = warn_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with hand-computed expected values.
module tb_countdown_timer;

`ifdef COUNTDOWN_WARN_EN
    localparam bit WARN_ON = 1'b1;
`else
    localparam bit WARN_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick, load, start, pause, abort;
    logic [3:0] load_d3, load_d2, load_d1, load_d0;
    logic [3:0] digit3, digit2, digit1, digit0;
    logic       running, time_up, expire_p, warn;

    int total = 0;
    int bad   = 0;

    countdown_timer dut (
        .clk(clk), .rst(rst), .tick(tick), .load(load),
        .load_d3(load_d3), .load_d2(load_d2), .load_d1(load_d1), .load_d0(load_d0),
        .start(start), .pause(pause), .abort(abort),
        .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
        .running(running), .time_up(time_up), .expire_p(expire_p), .warn(warn)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkTime(input string tag, input logic [15:0] expected);
        checkOutput(tag, int'({digit3, digit2, digit1, digit0}), int'(expected));
    endtask

    // Drive one cycle of inputs just after a rising edge, then clear them; outputs are
    // sampled 1 time unit after the edge that registered them.
    task automatic applyStimulus(input logic do_load, input logic [15:0] val,
                                 input logic do_start, input logic do_pause,
                                 input logic do_tick, input logic do_abort);
        load  = do_load;
        {load_d3, load_d2, load_d1, load_d0} = val;
        start = do_start;
        pause = do_pause;
        tick  = do_tick;
        abort = do_abort;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        tick  = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_t;
        rst = 1'b1;
        {tick, load, start, pause, abort} = '0;
        {load_d3, load_d2, load_d1, load_d0} = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkTime("reset_digits", 16'h0300);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_time_up", time_up, 0);
        checkOutput("reset_expire_p", expire_p, 0);
        checkOutput("reset_warn", warn, 0);

        // 00:02 runs down to expiry
        applyStimulus(1, 16'h0002, 0, 0, 0, 0);
        checkTime("load_0002", 16'h0002);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        checkOutput("start_running", running, 1);
        applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("tick_0001", 16'h0001);
        checkOutput("tick_0001_expire_p", expire_p, 0);
        applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("tick_0000", 16'h0000);
        checkOutput("expired_time_up", time_up, 1);
        checkOutput("expired_expire_p", expire_p, 1);
        checkOutput("expired_running", running, 0);
        applyStimulus(0, 16'h0, 0, 0, 0, 0);
        checkOutput("expire_p_one_cycle", expire_p, 0);
        checkOutput("expired_hold_time_up", time_up, 1);
        applyStimulus(0, 16'h0, 1, 0, 1, 0);
        checkTime("expired_ignores_start_tick", 16'h0000);
        checkOutput("expired_ignores_start", running, 0);

        // Full borrow chain 10:00 -> 09:59, load from EXPIRED
        applyStimulus(1, 16'h1000, 0, 0, 0, 0);
        checkTime("load_from_expired", 16'h1000);
        checkOutput("load_clears_time_up", time_up, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("borrow_1000", 16'h0959);
        applyStimulus(1, 16'h0100, 0, 0, 0, 0);
        checkTime("load_ignored_in_run", 16'h0959);
        applyStimulus(0, 16'h0, 0, 0, 0, 1);
        checkTime("abort_preset", 16'h0300);
        applyStimulus(1, 16'h0100, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("borrow_0100", 16'h0059);

        // Pause drops the same-cycle tick and holds through later ticks
        applyStimulus(0, 16'h0, 0, 0, 0, 1);
        applyStimulus(1, 16'h0030, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 1, 1, 0);
        checkTime("pause_drops_tick", 16'h0030);
        checkOutput("pause_running", running, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("pause_holds", 16'h0030);
        applyStimulus(0, 16'h0, 1, 1, 0, 0);
        checkOutput("pause_start_together", running, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        checkOutput("resume_running", running, 1);
        applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("resume_tick", 16'h0029);

        // Saturating load and start at zero
        applyStimulus(0, 16'h0, 0, 0, 0, 1);
        applyStimulus(1, 16'h7F9C, 0, 0, 0, 0);
        checkTime("saturate_load", 16'h5959);
        applyStimulus(1, 16'h0000, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        checkOutput("start_at_zero_running", running, 0);
        checkOutput("start_at_zero_time_up", time_up, 0);
        checkTime("start_at_zero_digits", 16'h0000);

        // Abort mid-RUN at 01:23
        applyStimulus(1, 16'h0124, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        applyStimulus(0, 16'h0, 0, 0, 1, 0);
        checkTime("run_0123", 16'h0123);
        applyStimulus(0, 16'h0, 0, 0, 0, 1);
        checkTime("abort_mid_run", 16'h0300);
        checkOutput("abort_running", running, 0);

        // Warn window: 00:11 down to 00:00
        applyStimulus(1, 16'h0011, 0, 0, 0, 0);
        applyStimulus(0, 16'h0, 1, 0, 0, 0);
        checkOutput("warn_at_11", warn, 0);
        for (int s = 10; s >= 0; s--) begin
            applyStimulus(0, 16'h0, 0, 0, 1, 0);
            exp_t = {8'h00, 4'(s / 10), 4'(s % 10)};
            checkTime($sformatf("warn_digits_%0d", s), exp_t);
            checkOutput($sformatf("warn_%0d", s), warn, int'(WARN_ON && (s > 0)));
        end
        checkOutput("warn_expired", time_up, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
